// File: rtl/append_crc.sv
// rtl/append_crc.sv - Ethernet FCS inserter for a 64-bit AXI-Stream TX path.
// Appends CRC-32 after the last valid byte, adding one beat when the FCS overflows the final beat.
module append_crc (
  input  logic        clock,
  input  logic        aresetn,
  input  logic [63:0] saxis_tdata,
  input  logic        saxis_tvalid,
  output logic        saxis_tready,
  input  logic [7:0]  saxis_tkeep,
  input  logic        saxis_tuser,
  input  logic        saxis_tlast,
  output logic [63:0] maxis_tdata,
  output logic        maxis_tvalid,
  input  logic        maxis_tready,
  output logic [7:0]  maxis_tkeep,
  output logic        maxis_tuser,
  output logic        maxis_tlast
);

  localparam logic [0:0] PASS  = 1'b0;
  localparam logic [0:0] EXTRA = 1'b1;

  logic [0:0]  state;
  logic [31:0] rem;
  logic [31:0] xtra_data;
  logic [7:0]  xtra_keep;
  logic        xtra_user;

  logic [3:0]  nbytes;
  logic [31:0] crc_next;
  logic [31:0] fcs;
  logic [63:0] payload;
  logic [63:0] merged;
  logic [31:0] extra;
  logic [7:0]  short_keep;
  logic [7:0]  extra_keep;
  logic        accept;
  logic        advance;

  function automatic logic [31:0] crc_byte(input logic [31:0] r, input logic [7:0] b);
    logic [31:0] c;
    c = r ^ {24'b0, b};
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
    end
    return c;
  endfunction

  always_comb begin
    nbytes     = 4'd0;
    crc_next   = rem;
    payload    = 64'b0;
    short_keep = 8'b0;
    extra_keep = 8'b0;
    for (int k = 0; k < 8; k++) begin
      if (saxis_tkeep[k]) nbytes = 4'(k + 1);
    end
    for (int k = 0; k < 8; k++) begin
      if (k < int'(nbytes)) begin
        crc_next = crc_byte(crc_next, saxis_tdata[8*k +: 8]);
        payload[8*k +: 8] = saxis_tdata[8*k +: 8];
      end
      short_keep[k] = (k < int'(nbytes) + 4);
      extra_keep[k] = (k < int'(nbytes) - 4);
    end
    fcs = ~crc_next;
    // FCS bytes that land past byte 7 fall off here and reappear in the extra beat.
    merged = payload | ({32'b0, fcs} << {nbytes, 3'b0});
    extra  = fcs >> {(4'd8 - nbytes), 3'b0};
  end

  assign advance      = !maxis_tvalid | maxis_tready;
  assign saxis_tready = aresetn & (state == PASS) & advance;
  assign accept       = saxis_tvalid & saxis_tready;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state        <= PASS;
      rem          <= 32'hFFFFFFFF;
      xtra_data    <= 32'b0;
      xtra_keep    <= 8'b0;
      xtra_user    <= 1'b0;
      maxis_tvalid <= 1'b0;
      maxis_tdata  <= 64'b0;
      maxis_tkeep  <= 8'b0;
      maxis_tlast  <= 1'b0;
      maxis_tuser  <= 1'b0;
    end else if (state == EXTRA) begin
      if (advance) begin
        maxis_tvalid <= 1'b1;
        maxis_tdata  <= {32'b0, xtra_data};
        maxis_tkeep  <= xtra_keep;
        maxis_tlast  <= 1'b1;
        maxis_tuser  <= xtra_user;
        state        <= PASS;
      end
    end else if (accept) begin
      maxis_tvalid <= 1'b1;
      if (!saxis_tlast) begin
        maxis_tdata <= saxis_tdata;
        maxis_tkeep <= 8'hFF;
        maxis_tlast <= 1'b0;
        maxis_tuser <= 1'b0;
        rem         <= crc_next;
      end else begin
        rem         <= 32'hFFFFFFFF;
        maxis_tdata <= merged;
        if (nbytes <= 4'd4) begin
          maxis_tkeep <= short_keep;
          maxis_tlast <= 1'b1;
          maxis_tuser <= saxis_tuser;
        end else begin
          maxis_tkeep <= 8'hFF;
          maxis_tlast <= 1'b0;
          maxis_tuser <= 1'b0;
          xtra_data   <= extra;
          xtra_keep   <= extra_keep;
          xtra_user   <= saxis_tuser;
          state       <= EXTRA;
        end
      end
    end else if (maxis_tready) begin
      maxis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_append_crc.sv
// tb/tb_append_crc.sv - bench for append_crc: directed FCS vectors, reset checks, random frames with stalls.
module tb_append_crc;

  logic        clock = 1'b0;
  logic        aresetn;
  logic [63:0] saxis_tdata;
  logic        saxis_tvalid;
  logic        saxis_tready;
  logic [7:0]  saxis_tkeep;
  logic        saxis_tuser;
  logic        saxis_tlast;
  logic [63:0] maxis_tdata;
  logic        maxis_tvalid;
  logic        maxis_tready;
  logic [7:0]  maxis_tkeep;
  logic        maxis_tuser;
  logic        maxis_tlast;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t       out_q[$];
  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        stall_en = 1'b0;
  logic        stalled = 1'b0;
  logic [74:0] prev_out;
  logic [7:0]  frame_bytes [0:31];

  append_crc dut (
    .clock(clock), .aresetn(aresetn),
    .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid), .saxis_tready(saxis_tready),
    .saxis_tkeep(saxis_tkeep), .saxis_tuser(saxis_tuser), .saxis_tlast(saxis_tlast),
    .maxis_tdata(maxis_tdata), .maxis_tvalid(maxis_tvalid), .maxis_tready(maxis_tready),
    .maxis_tkeep(maxis_tkeep), .maxis_tuser(maxis_tuser), .maxis_tlast(maxis_tlast)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  always @(posedge clock) begin
    #1;
    maxis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Output monitor: records handshakes and checks that stalled beats hold steady.
  always @(negedge clock) begin
    if (!aresetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stable", {maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tkeep, maxis_tdata}, prev_out);
      if (maxis_tvalid && maxis_tready)
        out_q.push_back('{maxis_tdata, maxis_tkeep, maxis_tlast, maxis_tuser});
      stalled  = maxis_tvalid && !maxis_tready;
      prev_out = {maxis_tvalid, maxis_tlast, maxis_tuser, maxis_tkeep, maxis_tdata};
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int waited = 0;
    saxis_tdata  = d;
    saxis_tkeep  = k;
    saxis_tlast  = l;
    saxis_tuser  = u;
    saxis_tvalid = 1'b1;
    @(negedge clock);
    while (!saxis_tready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("send_ready", saxis_tready, 1'b1);
    @(posedge clock);
    #1;
    saxis_tvalid = 1'b0;
  endtask

  task automatic expect_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    exp_q.push_back('{d, k, l, u});
  endtask

  task automatic compare_outputs(input string name);
    int waited = 0;
    int n;
    while (out_q.size() < exp_q.size() && waited < 20000) begin
      @(negedge clock);
      waited++;
    end
    repeat (3) @(negedge clock);
    check({name, ".count"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].data", name, i), out_q[i].data, exp_q[i].data);
      check($sformatf("%s[%0d].keep", name, i), out_q[i].keep, exp_q[i].keep);
      check($sformatf("%s[%0d].last", name, i), out_q[i].last, exp_q[i].last);
      check($sformatf("%s[%0d].user", name, i), out_q[i].user, exp_q[i].user);
    end
    out_q.delete();
    exp_q.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string name);
    aresetn      = 1'b0;
    saxis_tvalid = 1'b0;
    @(negedge clock);
    check({name, ".tvalid"}, maxis_tvalid, 1'b0);
    check({name, ".tdata"},  maxis_tdata,  64'h0);
    check({name, ".tkeep"},  maxis_tkeep,  8'h0);
    check({name, ".tlast"},  maxis_tlast,  1'b0);
    check({name, ".tuser"},  maxis_tuser,  1'b0);
    check({name, ".tready"}, saxis_tready, 1'b0);
    out_q.delete();
    @(posedge clock);
    #1;
    aresetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ref_crc(input int len);
    logic [31:0] r = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      r ^= {24'b0, frame_bytes[i]};
      for (int j = 0; j < 8; j++) r = (r >> 1) ^ (r[0] ? 32'hEDB88320 : 32'h0);
    end
    return ~r;
  endfunction

  task automatic random_frame();
    int          len  = $urandom_range(1, 24);
    logic        user = 1'($urandom_range(0, 1));
    logic [31:0] fcs;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    for (int i = 0; i < len; i++) frame_bytes[i] = 8'($urandom);
    fcs = ref_crc(len);
    for (int b = 0; b * 8 < len; b++) begin
      d = 64'b0;
      k = 8'b0;
      for (int j = 0; j < 8; j++) begin
        if (b * 8 + j < len) begin
          d[8*j +: 8] = frame_bytes[b*8+j];
          k[j] = 1'b1;
        end
      end
      l = (b * 8 + 8 >= len);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      send_beat(d, k, l, l ? user : 1'($urandom));
    end
    for (int i = 0; i < 4; i++) frame_bytes[len+i] = fcs[8*i +: 8];
    for (int b = 0; b * 8 < len + 4; b++) begin
      d = 64'b0;
      k = 8'b0;
      for (int j = 0; j < 8; j++) begin
        if (b * 8 + j < len + 4) begin
          d[8*j +: 8] = frame_bytes[b*8+j];
          k[j] = 1'b1;
        end
      end
      l = (b * 8 + 8 >= len + 4);
      expect_beat(d, k, l, l ? user : 1'b0);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles;
    aresetn      = 1'b0;
    saxis_tvalid = 1'b0;
    saxis_tdata  = 64'b0;
    saxis_tkeep  = 8'b0;
    saxis_tlast  = 1'b0;
    saxis_tuser  = 1'b0;
    maxis_tready = 1'b1;
    @(posedge clock);
    #1;
    do_reset("reset");

    // Back-to-back frames: "123456789", single 0x00, "1234".
    send_beat(64'h3837363534333231, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h39, 8'h01, 1'b1, 1'b1);
    send_beat(64'h00, 8'h01, 1'b1, 1'b0);
    send_beat(64'h34333231, 8'h0F, 1'b1, 1'b0);
    expect_beat(64'h3837363534333231, 8'hFF, 1'b0, 1'b0);
    expect_beat(64'h000000CBF4392639, 8'h1F, 1'b1, 1'b1);
    expect_beat(64'h000000D202EF8D00, 8'h1F, 1'b1, 1'b0);
    expect_beat(64'h9BE3E0A334333231, 8'hFF, 1'b1, 1'b0);
    compare_outputs("short");

    // "12345": FCS spills into an extra beat, costing one input bubble.
    send_beat(64'h3534333231, 8'h1F, 1'b1, 1'b0);
    bubbles = 0;
    repeat (4) begin
      @(negedge clock);
      if (!saxis_tready) bubbles++;
    end
    @(posedge clock);
    #1;
    check("bubble", bubbles, 1);
    expect_beat(64'hF53A1C3534333231, 8'hFF, 1'b0, 1'b0);
    expect_beat(64'h00000000000000CB, 8'h01, 1'b1, 1'b0);
    compare_outputs("five");

    // Full final beat with tuser, then an empty (tkeep 0) final beat.
    send_beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b1);
    send_beat(64'h3837363534333231, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h0, 8'h00, 1'b1, 1'b0);
    expect_beat(64'h3837363534333231, 8'hFF, 1'b0, 1'b0);
    expect_beat(64'h000000009AE0DAAF, 8'h0F, 1'b1, 1'b1);
    expect_beat(64'h3837363534333231, 8'hFF, 1'b0, 1'b0);
    expect_beat(64'h000000009AE0DAAF, 8'h0F, 1'b1, 1'b0);
    compare_outputs("eight");

    // Reset in the middle of a frame: the partial frame must not taint the next one.
    send_beat(64'h1122334455667788, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h99AABBCCDDEEFF00, 8'hFF, 1'b0, 1'b0);
    do_reset("midreset");
    send_beat(64'h3837363534333231, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h39, 8'h01, 1'b1, 1'b1);
    expect_beat(64'h3837363534333231, 8'hFF, 1'b0, 1'b0);
    expect_beat(64'h000000CBF4392639, 8'h1F, 1'b1, 1'b1);
    compare_outputs("after_reset");

    stall_en = 1'b1;
    for (int f = 0; f < 1000; f++) random_frame();
    compare_outputs("random");
    stall_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
